// File: rtl/muldiv.sv
// HI/LO multiply/divide unit: signed/unsigned 32x32 multiply, restoring divide, MTHI/MTLO.
//
//   state | meaning
//   IDLE  | waiting for start; MTHI/MTLO complete here without leaving IDLE
//   MUL   | multiply in flight (1 cycle fast, 32 shift-add cycles slow)
//   DIV   | 32 restoring iterations then one sign fix-up cycle
//   FIN   | hi/lo hold the new result, done pulses for one cycle
module muldiv #(
   parameter int FAST_MUL = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        cancel,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      FIN  = 2'd3
   } state_t;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   localparam logic [5:0] MUL_LAST_CNT = 6'd31;
   localparam logic [5:0] DIV_LAST_CNT = 6'd32;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q;
   logic        sgn_q;
   logic [31:0] a_q, b_q;
   logic [63:0] acc_q, mcand_q;
   logic [31:0] mplier_q;
   logic [31:0] rem_q, quo_q, dvsr_q;

   logic        accept, acc_mul, acc_div, acc_mthi, acc_mtlo, in_sgn;
   logic        mul_last, div_last, commit_mul, commit_div;
   logic [31:0] abs_a, abs_b;
   logic [63:0] ext_a, ext_b, fast_prod, acc_step, mul_result;
   logic [32:0] rem_sh, trial;
   logic [31:0] rem_step, quo_step, div_hi, div_lo;
   logic        q_neg, r_neg, b_zero;

   assign accept   = (state_q == IDLE) && start && !cancel;
   assign acc_mul  = accept && ((op == OP_MULT) || (op == OP_MULTU));
   assign acc_div  = accept && ((op == OP_DIV) || (op == OP_DIVU));
   assign acc_mthi = accept && (op == OP_MTHI);
   assign acc_mtlo = accept && (op == OP_MTLO);

   // MULT and DIV share op[0] == 0 as the signed flavour
   assign in_sgn = !op[0];
   assign abs_a  = (in_sgn && src_a[31]) ? (32'd0 - src_a) : src_a;
   assign abs_b  = (in_sgn && src_b[31]) ? (32'd0 - src_b) : src_b;

   assign mul_last   = (FAST_MUL != 0) || (cnt_q == MUL_LAST_CNT);
   assign div_last   = (cnt_q == DIV_LAST_CNT);
   assign commit_mul = (state_q == MUL) && !cancel && mul_last;
   assign commit_div = (state_q == DIV) && !cancel && div_last;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (acc_mul)      state_d = MUL;
            else if (acc_div) state_d = DIV;
         end
         MUL: begin
            busy = 1'b1;
            if (cancel)        state_d = IDLE;
            else if (mul_last) state_d = FIN;
         end
         DIV: begin
            busy = 1'b1;
            if (cancel)        state_d = IDLE;
            else if (div_last) state_d = FIN;
         end
         FIN: begin
            done    = !cancel;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Low 64 bits of the product of 64-bit extended operands equal the true product
   assign ext_a     = {{32{sgn_q & a_q[31]}}, a_q};
   assign ext_b     = {{32{sgn_q & b_q[31]}}, b_q};
   assign fast_prod = ext_a * ext_b;

   // Signed multiplier bit 31 carries weight -2^31, so the last step subtracts
   always_comb begin
      acc_step = acc_q;
      if (mplier_q[0]) begin
         if (sgn_q && (cnt_q == MUL_LAST_CNT)) acc_step = acc_q - mcand_q;
         else                                  acc_step = acc_q + mcand_q;
      end
   end

   assign mul_result = (FAST_MUL != 0) ? fast_prod : acc_step;

   assign rem_sh   = {rem_q, quo_q[31]};
   assign trial    = rem_sh - {1'b0, dvsr_q};
   assign rem_step = trial[32] ? rem_sh[31:0] : trial[31:0];
   assign quo_step = {quo_q[30:0], ~trial[32]};

   assign q_neg  = sgn_q & (a_q[31] ^ b_q[31]);
   assign r_neg  = sgn_q & a_q[31];
   assign b_zero = (b_q == 32'd0);
   assign div_lo = b_zero ? 32'hFFFF_FFFF : (q_neg ? (32'd0 - quo_q) : quo_q);
   assign div_hi = b_zero ? a_q : (r_neg ? (32'd0 - rem_q) : rem_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q    <= '0;
         sgn_q    <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvsr_q   <= '0;
      end else if (acc_mul || acc_div) begin
         cnt_q    <= '0;
         sgn_q    <= in_sgn;
         a_q      <= src_a;
         b_q      <= src_b;
         acc_q    <= '0;
         mcand_q  <= {{32{in_sgn & src_a[31]}}, src_a};
         mplier_q <= src_b;
         rem_q    <= '0;
         quo_q    <= abs_a;
         dvsr_q   <= abs_b;
      end else if ((state_q == MUL) || (state_q == DIV)) begin
         cnt_q    <= cnt_q + 6'd1;
         acc_q    <= acc_step;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         rem_q    <= rem_step;
         quo_q    <= quo_step;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hi <= '0;
         lo <= '0;
      end else begin
         if (acc_mthi) hi <= src_a;
         if (acc_mtlo) lo <= src_a;
         if (commit_mul) begin
            hi <= mul_result[63:32];
            lo <= mul_result[31:0];
         end
         if (commit_div) begin
            hi <= div_hi;
            lo <= div_lo;
         end
      end
   end

endmodule

// File: tb/tb_muldiv.sv
// Directed bench for muldiv: fast and slow multiply instances share all inputs.
module tb_muldiv;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] h;
      logic [31:0] l;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, start, cancel;
   logic [2:0]  op;
   logic [31:0] src_a, src_b;
   logic        busy_f, done_f, busy_s, done_s;
   logic [31:0] hi_f, lo_f, hi_s, lo_s;

   int vectors = 0;
   int errors  = 0;

   int          kf, ks, nf, ns;
   logic [31:0] hf_r, lf_r, hs_r, ls_r, hf0, lf0, hs0, ls0;
   logic        chg_f, chg_s, bf1, bs1;

   vec_t mul_tab [5] = '{
      '{OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA},
      '{OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA},
      '{OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001},
      '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001},
      '{OP_MULT,  32'h1234_5678, 32'hFFFF_FFF0, 32'hFFFF_FFFE, 32'hDCBA_9880}
   };

   vec_t div_tab [7] = '{
      '{OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD},
      '{OP_DIVU, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003},
      '{OP_DIVU, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF},
      '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000},
      '{OP_DIV,  32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD},
      '{OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF},
      '{OP_DIV,  32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF}
   };

   muldiv #(.FAST_MUL(1)) dut_f (
      .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
      .cancel(cancel), .busy(busy_f), .done(done_f), .hi(hi_f), .lo(lo_f)
   );

   muldiv #(.FAST_MUL(0)) dut_s (
      .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
      .cancel(cancel), .busy(busy_s), .done(done_s), .hi(hi_s), .lo(lo_s)
   );

   always #5 clk = ~clk;

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time exceeded");
      $fatal(1);
   end

   // Start strobe for one edge, then scramble inputs so unlatched operands would show
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      hf0 = hi_f; lf0 = lo_f; hs0 = hi_s; ls0 = lo_s;
      start = 1'b1; op = o; src_a = a; src_b = b;
      @(negedge clk);
      start = 1'b0; op = 3'b111; src_a = 32'h1357_2468; src_b = 32'h0;
   endtask

   task automatic clear_watch();
      kf = 0; ks = 0; nf = 0; ns = 0;
      chg_f = 1'b0; chg_s = 1'b0;
      hf_r = '0; lf_r = '0; hs_r = '0; ls_r = '0;
   endtask

   task automatic sample(input int k);
      if (k == 1) begin bf1 = busy_f; bs1 = busy_s; end
      if (done_f) begin
         nf++;
         if (kf == 0) begin kf = k; hf_r = hi_f; lf_r = lo_f; end
      end else if (kf == 0 && (hi_f !== hf0 || lo_f !== lf0)) chg_f = 1'b1;
      if (done_s) begin
         ns++;
         if (ks == 0) begin ks = k; hs_r = hi_s; ls_r = lo_s; end
      end else if (ks == 0 && (hi_s !== hs0 || lo_s !== ls0)) chg_s = 1'b1;
   endtask

   task automatic watch(input int maxc);
      clear_watch();
      for (int k = 1; k <= maxc; k++) begin
         if (k > 1) @(negedge clk);
         sample(k);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; cancel = 1'b0; op = 3'b000; src_a = '0; src_b = '0;
      #1;
      vectors++; if ({busy_f, done_f, busy_s, done_s} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {busy_f, done_f, busy_s, done_s}); end
      vectors++; if ({hi_f, lo_f} !== 64'd0) begin errors++; $display("FAIL reset_hilo_fast: got %h expected 0", {hi_f, lo_f}); end
      vectors++; if ({hi_s, lo_s} !== 64'd0) begin errors++; $display("FAIL reset_hilo_slow: got %h expected 0", {hi_s, lo_s}); end
      repeat (2) @(negedge clk);
      rst = 1'b1; start = 1'b1; op = OP_MTHI; src_a = 32'h0BAD_F00D;
      @(negedge clk);
      start = 1'b0;
      vectors++; if (hi_f !== 32'h0BAD_F00D) begin errors++; $display("FAIL reset_first_edge_fast: got %h expected 0badf00d", hi_f); end
      vectors++; if (hi_s !== 32'h0BAD_F00D) begin errors++; $display("FAIL reset_first_edge_slow: got %h expected 0badf00d", hi_s); end
   endtask

   task automatic test_mt();
      @(negedge clk);
      start = 1'b1; op = OP_MTHI; src_a = 32'hA5A5_A5A5;
      @(negedge clk);
      vectors++; if ({hi_f, hi_s} !== {2{32'hA5A5_A5A5}}) begin errors++; $display("FAIL mthi: got %h %h expected a5a5a5a5", hi_f, hi_s); end
      vectors++; if ({busy_f, done_f, busy_s, done_s} !== 4'b0000) begin errors++; $display("FAIL mthi_flags: got %b expected 0000", {busy_f, done_f, busy_s, done_s}); end
      op = OP_MTLO; src_a = 32'h5A5A_5A5A;
      @(negedge clk);
      start = 1'b0;
      vectors++; if ({lo_f, lo_s} !== {2{32'h5A5A_5A5A}}) begin errors++; $display("FAIL mtlo: got %h %h expected 5a5a5a5a", lo_f, lo_s); end
      vectors++; if ({hi_f, hi_s} !== {2{32'hA5A5_A5A5}}) begin errors++; $display("FAIL mtlo_hi_hold: got %h %h expected a5a5a5a5", hi_f, hi_s); end
      vectors++; if ({busy_f, done_f, busy_s, done_s} !== 4'b0000) begin errors++; $display("FAIL mtlo_flags: got %b expected 0000", {busy_f, done_f, busy_s, done_s}); end
      start = 1'b1; op = 3'b110; src_a = 32'hFFFF_0000; src_b = 32'h1;
      @(negedge clk);
      op = 3'b111;
      @(negedge clk);
      start = 1'b0;
      vectors++; if ({hi_f, lo_f} !== {32'hA5A5_A5A5, 32'h5A5A_5A5A}) begin errors++; $display("FAIL reserved_hilo: got %h expected a5a5a5a55a5a5a5a", {hi_f, lo_f}); end
      vectors++; if ({busy_f, busy_s} !== 2'b00) begin errors++; $display("FAIL reserved_busy: got %b expected 00", {busy_f, busy_s}); end
   endtask

   task automatic test_mul();
      for (int i = 0; i < 5; i++) begin
         vec_t t;
         t = mul_tab[i];
         issue(t.op, t.a, t.b);
         watch(35);
         vectors++; if ({bf1, bs1} !== 2'b11) begin errors++; $display("FAIL mul%0d_busy: got %b expected 11", i, {bf1, bs1}); end
         vectors++; if (kf != 2) begin errors++; $display("FAIL mul%0d_lat_fast: got %0d expected 2", i, kf); end
         vectors++; if (ks != 33) begin errors++; $display("FAIL mul%0d_lat_slow: got %0d expected 33", i, ks); end
         vectors++; if ({hf_r, lf_r} !== {t.h, t.l}) begin errors++; $display("FAIL mul%0d_fast: got %h expected %h", i, {hf_r, lf_r}, {t.h, t.l}); end
         vectors++; if ({hs_r, ls_r} !== {t.h, t.l}) begin errors++; $display("FAIL mul%0d_slow: got %h expected %h", i, {hs_r, ls_r}, {t.h, t.l}); end
         vectors++; if ({nf, ns} != {32'd1, 32'd1} || chg_f || chg_s) begin errors++; $display("FAIL mul%0d_pulse_hold: got %0d %0d %b%b expected 1 1 00", i, nf, ns, chg_f, chg_s); end
      end
   endtask

   task automatic test_div();
      for (int i = 0; i < 7; i++) begin
         vec_t t;
         t = div_tab[i];
         issue(t.op, t.a, t.b);
         watch(35);
         vectors++; if ({bf1, bs1} !== 2'b11) begin errors++; $display("FAIL div%0d_busy: got %b expected 11", i, {bf1, bs1}); end
         vectors++; if (kf != 34 || ks != 34) begin errors++; $display("FAIL div%0d_lat: got %0d %0d expected 34 34", i, kf, ks); end
         vectors++; if ({hf_r, lf_r} !== {t.h, t.l}) begin errors++; $display("FAIL div%0d_fast: got %h expected %h", i, {hf_r, lf_r}, {t.h, t.l}); end
         vectors++; if ({hs_r, ls_r} !== {t.h, t.l}) begin errors++; $display("FAIL div%0d_slow: got %h expected %h", i, {hs_r, ls_r}, {t.h, t.l}); end
         vectors++; if ({nf, ns} != {32'd1, 32'd1} || chg_f || chg_s) begin errors++; $display("FAIL div%0d_pulse_hold: got %0d %0d %b%b expected 1 1 00", i, nf, ns, chg_f, chg_s); end
      end
   endtask

   task automatic test_back_to_back();
      issue(OP_DIV, 32'd100, 32'd7);
      clear_watch();
      for (int k = 1; k <= 36; k++) begin
         if (k > 1) @(negedge clk);
         sample(k);
         if (k == 10) begin start = 1'b1; op = OP_DIV; src_a = 32'd1; src_b = 32'd1; end
         else if (k == 11) start = 1'b0;
         if (k == 34) begin start = 1'b1; op = OP_MTHI; src_a = 32'hDEAD_BEEF; end
         else if (k == 35) start = 1'b0;
      end
      vectors++; if (kf != 34 || nf != 1) begin errors++; $display("FAIL b2b_pulse: got lat %0d count %0d expected 34 1", kf, nf); end
      vectors++; if ({hf_r, lf_r} !== {32'd2, 32'd14}) begin errors++; $display("FAIL b2b_result: got %h expected %h", {hf_r, lf_r}, {32'd2, 32'd14}); end
      vectors++; if ({hi_f, hi_s, lo_s} !== {32'd2, 32'd2, 32'd14}) begin errors++; $display("FAIL b2b_fin_start: got %h %h %h expected 2 2 e", hi_f, hi_s, lo_s); end
      vectors++; if ({busy_f, busy_s, ns} !== {2'b00, 32'd1}) begin errors++; $display("FAIL b2b_idle: got %b %b %0d expected 0 0 1", busy_f, busy_s, ns); end
   endtask

   task automatic test_cancel();
      @(negedge clk);
      start = 1'b1; op = OP_MTHI; src_a = 32'h1111_1111;
      @(negedge clk);
      op = OP_MTLO; src_a = 32'h2222_2222;
      @(negedge clk);
      start = 1'b0;
      issue(OP_DIV, 32'd100, 32'd7);
      for (int k = 2; k <= 20; k++) @(negedge clk);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      vectors++; if ({busy_f, done_f, busy_s, done_s} !== 4'b0000) begin errors++; $display("FAIL cancel_flags: got %b expected 0000", {busy_f, done_f, busy_s, done_s}); end
      vectors++; if ({hi_f, lo_f, hi_s, lo_s} !== {2{32'h1111_1111, 32'h2222_2222}}) begin errors++; $display("FAIL cancel_hilo: got %h %h expected 11111111 22222222", hi_f, lo_f); end
      watch(20);
      vectors++; if (nf != 0 || ns != 0 || chg_f || chg_s) begin errors++; $display("FAIL cancel_no_done: got %0d %0d %b%b expected 0 0 00", nf, ns, chg_f, chg_s); end
      @(negedge clk);
      cancel = 1'b1; start = 1'b1; op = OP_MTHI; src_a = 32'h3333_3333;
      @(negedge clk);
      op = OP_MULT; src_a = 32'd5; src_b = 32'd5;
      @(negedge clk);
      cancel = 1'b0; start = 1'b0;
      vectors++; if ({hi_f, hi_s} !== {2{32'h1111_1111}}) begin errors++; $display("FAIL cancel_start_mthi: got %h %h expected 11111111", hi_f, hi_s); end
      vectors++; if ({busy_f, busy_s} !== 2'b00) begin errors++; $display("FAIL cancel_start_mult: got %b expected 00", {busy_f, busy_s}); end
      issue(OP_DIVU, 32'd9, 32'd2);
      for (int k = 2; k <= 34; k++) @(negedge clk);
      vectors++; if ({done_f, done_s} !== 2'b11) begin errors++; $display("FAIL fin_reached: got %b expected 11", {done_f, done_s}); end
      cancel = 1'b1;
      #1;
      vectors++; if ({done_f, done_s} !== 2'b00) begin errors++; $display("FAIL fin_cancel_done: got %b expected 00", {done_f, done_s}); end
      @(negedge clk);
      cancel = 1'b0;
      vectors++; if ({busy_f, done_f, busy_s, done_s} !== 4'b0000) begin errors++; $display("FAIL fin_cancel_idle: got %b expected 0000", {busy_f, done_f, busy_s, done_s}); end
   endtask

   task automatic test_reset_mid();
      issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
      for (int k = 2; k <= 10; k++) @(negedge clk);
      vectors++; if (busy_s !== 1'b1) begin errors++; $display("FAIL rstmid_busy: got %b expected 1", busy_s); end
      #2 rst = 1'b0;
      #1;
      vectors++; if ({busy_s, done_s, busy_f, done_f} !== 4'b0000) begin errors++; $display("FAIL rstmid_flags: got %b expected 0000", {busy_s, done_s, busy_f, done_f}); end
      vectors++; if ({hi_s, lo_s, hi_f, lo_f} !== 128'd0) begin errors++; $display("FAIL rstmid_hilo: got %h %h %h %h expected 0", hi_s, lo_s, hi_f, lo_f); end
      @(negedge clk);
      rst = 1'b1;
      issue(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
      watch(35);
      vectors++; if (kf != 2 || ks != 33) begin errors++; $display("FAIL rstmid_relat: got %0d %0d expected 2 33", kf, ks); end
      vectors++; if ({hs_r, ls_r, hf_r, lf_r} !== {2{32'h2, 32'hFFFF_FFFA}}) begin errors++; $display("FAIL rstmid_reresult: got %h %h expected 00000002 fffffffa", hs_r, ls_r); end
   endtask

   initial begin
      test_reset();
      test_mt();
      test_mul();
      test_div();
      test_back_to_back();
      test_cancel();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
